bcd_to_unsigned: RTL

- Sequential reverse double-dabble converter: packed BCD digits in, unsigned binary out.
- Inverse of the unsigned-to-BCD path used by the clock display.
- Used by the time-setting/alarm logic to turn user-entered BCD digits (from switches/buttons) back into a binary seconds/minutes value.
- trigger/idle handshake, one shift per clock; a parallel multiply-add chain is not used.

---
 rtl/bcd_to_unsigned_if.sv | 30 +++
 rtl/bcd_to_unsigned.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bcd_to_unsigned_if.sv
// ============================================================================
// Module      : bcd_to_unsigned_if
// Description : Start/result handshake bundle for the BCD-to-binary converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_to_unsigned_if #(
    parameter int DIGITS = 8,
    parameter int BITS   = 32
);
    logic                  trigger;
    logic [DIGITS*4-1:0]   bcd;
    logic                  idle;
    logic                  done;
    logic [BITS-1:0]       out;
    logic                  err;

    modport master (
        output trigger, bcd,
        input  idle, done, out, err
    );

    modport slave (
        input  trigger, bcd,
        output idle, done, out, err
    );
endinterface

`default_nettype wire

// File: rtl/bcd_to_unsigned.sv
// ============================================================================
// Module      : bcd_to_unsigned
// Description : Sequential reverse double-dabble converter, packed BCD in,
//               unsigned binary out, one shift per clock.
//               Optional macro BCD_CHECK_EN enables invalid-digit detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_unsigned #(
    parameter int DIGITS = 8,
    parameter int BITS   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_to_unsigned_if.slave  bus
);

    localparam int                   c_BCD_W = DIGITS * 4;
    localparam int                   c_CNT_W = $clog2(BITS) + 1;
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(BITS - 1);
    localparam logic [c_CNT_W-1:0]   c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [c_BCD_W-1:0]     r_bcd;
    logic [BITS-1:0]        r_bin;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [BITS-1:0]        r_out;

    logic [c_BCD_W-1:0]     w_bcd_shr;
    logic [c_BCD_W-1:0]     w_bcd_adj;
    logic [BITS-1:0]        w_bin_shr;
    logic                   w_accept;
    logic                   w_last;

    // One right shift of the combined {bcd, bin} working register.
    assign {w_bcd_shr, w_bin_shr} = {1'b0, r_bcd, r_bin[BITS-1:1]};

    // A digit that received the bit shifted down from its neighbour carries
    // +8 where +5 (half of ten) is wanted, hence the -3 correction.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_adj
            always_comb begin
                if (w_bcd_shr[4*i +: 4] >= 4'd8) begin
                    w_bcd_adj[4*i +: 4] = w_bcd_shr[4*i +: 4] - 4'd3;
                end else begin
                    w_bcd_adj[4*i +: 4] = w_bcd_shr[4*i +: 4];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.trigger) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_bcd <= bus.bcd;
            r_bin <= '0;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_bcd <= w_bcd_adj;
            r_bin <= w_bin_shr;
            r_cnt <= r_cnt + c_ONE;
        end
    end

`ifdef BCD_CHECK_EN
    logic [DIGITS-1:0]      w_digit_bad;
    logic                   r_err_pend;
    logic                   r_err;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_chk
            assign w_digit_bad[i] = (bus.bcd[4*i +: 4] > 4'd9);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pend <= 1'b0;
        end else if (w_accept) begin
            r_err_pend <= |w_digit_bad;
        end
    end

    // The result is committed as the final shift lands, so out/err are
    // already valid during the single cycle that done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_err <= 1'b0;
        end else if (w_last) begin
            r_out <= r_err_pend ? '0 : w_bin_shr;
            r_err <= r_err_pend;
        end
    end

    assign bus.err = r_err;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_last) begin
            r_out <= w_bin_shr;
        end
    end

    assign bus.err = 1'b0;
`endif

    assign bus.out  = r_out;
    assign bus.idle = (r_state == S_IDLE);
    assign bus.done = (r_state == S_DONE);

endmodule

`default_nettype wire
